vdp_vram_sched: RTL and testbench
=================================

VDP_VRAM_SCHED -- requirements
Module: vdp_vram_sched

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have ports wr0_tick/rd0_tick, input, 1 each, one-cycle CPU mode0 (data port) write/read strobes.
REQ-004 SHALL have ports wr1_tick/rd1_tick, input, 1 each, one-cycle CPU mode1 (control port) write/read strobes.
REQ-005 SHALL have port din, input, 8, CPU write data, stable during wr0_tick/wr1_tick.
REQ-006 SHALL have port dout, output, 8, read-ahead buffer presented to CPU on mode0 read.
REQ-007 SHALL have ports disp_req (input, 1), disp_addr (input, 14), disp_gnt (output, 1), disp_valid (output, 1), disp_data (output, 8), display fetch requester.
REQ-008 SHALL have ports vram_addr (output, 14), vram_wdata (output, 8), vram_we (output, 1), vram_re (output, 1), vram_rdata (input, 8), VRAM with read latency of exactly 1 clk.
REQ-009 SHALL have ports busy (output, 1) = CPU op pending, and ovr (output, 1) = sticky CPU overrun flag.

Function
REQ-010 SHALL keep a 1-bit control-port byte state: wr1_tick with state 0 latches din into addr_lo and sets state 1; wr1_tick with state 1 decodes din[7:6] and clears state.
REQ-011 On second byte, din[7:6]=00 SHALL load addr={din[5:0],addr_lo}, cancel any pending op, and schedule a read-ahead; 01 SHALL load addr identically, cancel pending, and schedule nothing; 10/11 SHALL leave addr unchanged (register write, handled elsewhere).
REQ-012 rd1_tick SHALL clear the byte state to 0; if coincident with wr1_tick, rd1_tick wins.
REQ-013 wr0_tick while not busy SHALL latch din into wbuf and schedule a write; rd0_tick while not busy SHALL schedule a read-ahead (dout unchanged until it completes).
REQ-014 wr0_tick or rd0_tick while busy SHALL be discarded and SHALL set ovr; ovr SHALL clear on rd1_tick.
REQ-015 Arbiter states SHALL be IDLE, RD_WAIT; display SHALL have strict priority over CPU on every cycle.
REQ-016 Any cycle with disp_req=1 SHALL assert disp_gnt=1, vram_re=1, vram_addr=disp_addr combinationally; disp_valid SHALL assert exactly 1 clk later with disp_data=vram_rdata.
REQ-017 Cycle with disp_req=0, pending write, state IDLE: SHALL drive vram_we=1, vram_addr=addr, vram_wdata=wbuf for 1 clk; next clk addr increments and busy clears.
REQ-018 Cycle with disp_req=0, pending read, state IDLE: SHALL drive vram_re=1, vram_addr=addr, go to RD_WAIT; in RD_WAIT capture vram_rdata into rdbuf, increment addr, clear busy, return IDLE.
REQ-019 Display grants SHALL be permitted during RD_WAIT; CPU issue SHALL NOT occur in RD_WAIT.
REQ-020 addr SHALL be 14 bits and wrap 0x3FFF -> 0x0000 on increment.
REQ-021 A control-port address load coincident with RD_WAIT capture SHALL take precedence: new addr kept, no increment, captured data still written to rdbuf only if the cancelled op was not superseded by a new read setup.
REQ-022 Worst-case CPU latency SHALL be unbounded only while disp_req stays high; otherwise a pending op SHALL complete within 2 clk.

Reset
REQ-023 reset SHALL force: state IDLE, byte state 0, addr 0, addr_lo 0, wbuf 0, rdbuf 0, busy 0, ovr 0, disp_valid 0.
REQ-024 reset SHALL drive vram_we=0, vram_re=0, disp_gnt=0 and discard any pending or in-flight op; reset mid-RD_WAIT SHALL leave rdbuf at 0.

Configuration
REQ-025 With VDP_WRBUF_ECHO_EN defined, a completed CPU write SHALL also copy wbuf into rdbuf in the same clk as addr increments (TMS9918 behaviour).
REQ-026 Without VDP_WRBUF_ECHO_EN, rdbuf SHALL change only on read-ahead capture or reset.

Verification
REQ-027 wr1 0x34, wr1 0x52 (01), wr0 0xAA, disp_req=0 -> vram_we with addr 0x1234 data 0xAA, then addr=0x1235, busy=0.
REQ-028 wr1 0xFF, wr1 0x3F (00), VRAM[0x3FFF]=0x5C -> vram_re at 0x3FFF, dout=0x5C two clk later, addr=0x0000.
REQ-029 Pending write with disp_req held high 5 clk -> five disp_gnt cycles, no vram_we, write issued on first clk disp_req=0.
REQ-030 wr0 then wr0 on next clk while busy with disp_req=1 -> second dropped, ovr=1; rd1_tick -> ovr=0.
REQ-031 wr1 0x10, rd1_tick, wr1 0x20, wr1 0x40 (01) -> addr=0x0020 (first byte discarded).
REQ-032 Write 0x77 at 0x0100 with VDP_WRBUF_ECHO_EN -> dout=0x77; without macro -> dout unchanged.

Source files
------------

// File: rtl/vdp_vram_sched.sv
// VRAM access scheduler: display fetches get strict priority; CPU data-port reads and writes run in the idle cycles.
// Define VDP_WRBUF_ECHO_EN to echo each completed CPU write byte into the read-ahead buffer.
module vdp_vram_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr0_tick,
  input  logic        rd0_tick,
  input  logic        wr1_tick,
  input  logic        rd1_tick,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        disp_req,
  input  logic [13:0] disp_addr,
  output logic        disp_gnt,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [7:0]  vram_rdata,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t      state, state_nxt;
  logic        byte_st;
  logic [7:0]  addr_lo;
  logic [13:0] addr;
  logic [7:0]  wbuf;
  logic [7:0]  rdbuf;
  logic        pend_wr;

  logic        ctrl_hi, addr_load, rd_setup, cpu_req;
  logic        issue_wr, issue_rd, capture;

  assign ctrl_hi   = wr1_tick & ~rd1_tick & byte_st;
  assign addr_load = ctrl_hi & ~din[7];
  assign rd_setup  = addr_load & ~din[6];
  assign cpu_req   = wr0_tick | rd0_tick;

  assign dout       = rdbuf;
  assign disp_data  = vram_rdata;
  assign vram_wdata = wbuf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Display wins the port every cycle; the CPU only issues from IDLE.
  always_comb begin
    state_nxt = state;
    disp_gnt  = 1'b0;
    vram_re   = 1'b0;
    vram_we   = 1'b0;
    vram_addr = addr;
    issue_wr  = 1'b0;
    issue_rd  = 1'b0;
    capture   = 1'b0;
    if (!reset) begin
      if (disp_req) begin
        disp_gnt  = 1'b1;
        vram_re   = 1'b1;
        vram_addr = disp_addr;
      end
      case (state)
        IDLE: begin
          if (!disp_req && busy) begin
            if (pend_wr) begin
              vram_we  = 1'b1;
              issue_wr = 1'b1;
            end else begin
              vram_re  = 1'b1;
              issue_rd = 1'b1;
              if (!addr_load) state_nxt = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_st    <= 1'b0;
      addr_lo    <= 8'h00;
      addr       <= 14'h0000;
      wbuf       <= 8'h00;
      rdbuf      <= 8'h00;
      busy       <= 1'b0;
      pend_wr    <= 1'b0;
      ovr        <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_req;

      if (rd1_tick) begin
        byte_st <= 1'b0;
      end else if (wr1_tick) begin
        if (!byte_st) begin
          addr_lo <= din;
          byte_st <= 1'b1;
        end else begin
          byte_st <= 1'b0;
        end
      end

      if (cpu_req && busy) ovr <= 1'b1;
      else if (rd1_tick)   ovr <= 1'b0;

      // A new address load cancels whatever op is outstanding, including one completing now.
      if (addr_load) begin
        addr    <= {din[5:0], addr_lo};
        busy    <= rd_setup;
        pend_wr <= 1'b0;
        if (capture && !rd_setup) rdbuf <= vram_rdata;
      end else begin
        if (issue_wr) begin
          addr <= addr + 14'd1;
          busy <= 1'b0;
`ifdef VDP_WRBUF_ECHO_EN
          rdbuf <= wbuf;
`endif
        end
        if (capture) begin
          rdbuf <= vram_rdata;
          addr  <= addr + 14'd1;
          busy  <= 1'b0;
        end
        if (!busy && cpu_req) begin
          busy    <= 1'b1;
          pend_wr <= wr0_tick;
          if (wr0_tick) wbuf <= din;
        end
      end
    end
  end

endmodule

// File: tb/tb_vdp_vram_sched.sv
// Self-checking bench for vdp_vram_sched: directed scenarios plus a randomized op stream checked against a transaction model.
module tb_vdp_vram_sched;

  logic        clk = 1'b0;
  logic        reset, wr0_tick, rd0_tick, wr1_tick, rd1_tick;
  logic [7:0]  din, dout;
  logic        disp_req, disp_gnt, disp_valid;
  logic [13:0] disp_addr, vram_addr;
  logic [7:0]  disp_data, vram_wdata, vram_rdata;
  logic        vram_we, vram_re, busy, ovr;

  int checks = 0;
  int errors = 0;

  vdp_vram_sched dut (
    .clk(clk), .reset(reset),
    .wr0_tick(wr0_tick), .rd0_tick(rd0_tick), .wr1_tick(wr1_tick), .rd1_tick(rd1_tick),
    .din(din), .dout(dout),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
    .vram_rdata(vram_rdata), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  // VRAM: unwritten locations read back a fixed address pattern, 1-clk read latency.
  logic        mem_clr, poke_en;
  logic [13:0] poke_addr;
  logic [7:0]  poke_dat;
  logic [7:0]  vmem [0:16383];
  logic [16383:0] vset;

  always @(posedge clk) begin
    if (mem_clr) begin
      vset <= '0;
    end else begin
      if (vram_re) vram_rdata <= vset[vram_addr] ? vmem[vram_addr] : pat(vram_addr);
      if (vram_we) begin vmem[vram_addr] <= vram_wdata; vset[vram_addr] <= 1'b1; end
      if (poke_en) begin vmem[poke_addr] <= poke_dat;   vset[poke_addr] <= 1'b1; end
    end
  end

  // Reference model: expected memory contents, CPU address pointer and read-ahead buffer.
  logic [7:0]  ref_mem [logic [13:0]];
  logic [13:0] m_addr;
  logic [7:0]  m_rdbuf;

  function automatic logic [7:0] ref_get(input logic [13:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  task automatic model_wr(input logic [7:0] d);
    ref_mem[m_addr] = d;
    m_addr = m_addr + 14'd1;
`ifdef VDP_WRBUF_ECHO_EN
    m_rdbuf = d;
`endif
  endtask

  task automatic model_rd();
    m_rdbuf = ref_get(m_addr);
    m_addr  = m_addr + 14'd1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic wr1(input logic [7:0] b); wr1_tick = 1'b1; din = b; step(); wr1_tick = 1'b0; endtask
  task automatic wr0(input logic [7:0] b); wr0_tick = 1'b1; din = b; step(); wr0_tick = 1'b0; endtask
  task automatic rd0(); rd0_tick = 1'b1; step(); rd0_tick = 1'b0; endtask
  task automatic rd1(); rd1_tick = 1'b1; step(); rd1_tick = 1'b0; endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1; disp_req = 1'b1; disp_addr = 14'h0155;
    step(); step();
    @(negedge clk);
    checks++;
    if ({disp_gnt, vram_re, vram_we, busy, ovr, disp_valid, dout} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b re=%b we=%b busy=%b ovr=%b valid=%b dout=%h want all 0",
               disp_gnt, vram_re, vram_we, busy, ovr, disp_valid, dout);
    end
    step();
    reset = 1'b0; mem_clr = 1'b0; disp_req = 1'b0;
    m_addr = 14'h0; m_rdbuf = 8'h00;
    step();
  endtask

  task automatic test_write();
    wr1(8'h34); wr1(8'h52); wr0(8'hAA);
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h1234 || vram_wdata !== 8'hAA || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_issue got we=%b addr=%h data=%h busy=%b want 1/1234/aa/1", vram_we, vram_addr, vram_wdata, busy);
    end
    m_addr = 14'h1234; model_wr(8'hAA);
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vram_we !== 1'b0) begin
      errors++;
      $display("FAIL write_done got busy=%b we=%b want 0/0", busy, vram_we);
    end
    step();
    wr0(8'h3C);
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h1235) begin
      errors++;
      $display("FAIL write_incr got we=%b addr=%h want 1/1235", vram_we, vram_addr);
    end
    model_wr(8'h3C);
    step();
  endtask

  task automatic test_read_wrap();
    poke_en = 1'b1; poke_addr = 14'h3FFF; poke_dat = 8'h5C; step(); poke_en = 1'b0;
    ref_mem[14'h3FFF] = 8'h5C;
    wr1(8'hFF); wr1(8'h3F);
    m_addr = 14'h3FFF;
    @(negedge clk);
    checks++;
    if (vram_re !== 1'b1 || vram_addr !== 14'h3FFF || dout !== m_rdbuf) begin
      errors++;
      $display("FAIL read_issue got re=%b addr=%h dout=%h want 1/3fff/%h", vram_re, vram_addr, dout, m_rdbuf);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dout !== m_rdbuf) begin
      errors++;
      $display("FAIL read_wait got busy=%b dout=%h want 1/%h", busy, dout, m_rdbuf);
    end
    step();
    @(negedge clk);
    model_rd();
    checks++;
    if (dout !== 8'h5C || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_data got dout=%h busy=%b want 5c/0", dout, busy);
    end
    step();
    wr0(8'h21);
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h0000) begin
      errors++;
      $display("FAIL read_wrap got we=%b addr=%h want 1/0000", vram_we, vram_addr);
    end
    model_wr(8'h21);
    step();
  endtask

  task automatic test_disp_priority();
    logic [7:0] exp_d [5];
    int gnts = 0;
    wr1(8'h80); wr1(8'h45);
    m_addr = 14'h0580;
    wr0(8'hD1);
    disp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      disp_addr = 14'($urandom);
      @(negedge clk);
      if (disp_gnt === 1'b1) gnts++;
      checks++;
      if (vram_we !== 1'b0 || vram_re !== 1'b1 || vram_addr !== disp_addr || busy !== 1'b1) begin
        errors++;
        $display("FAIL disp_prio cyc%0d got we=%b re=%b addr=%h busy=%b want 0/1/%h/1", i, vram_we, vram_re, vram_addr, busy, disp_addr);
      end
      exp_d[i] = ref_get(disp_addr);
      if (i > 0) begin
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== exp_d[i-1]) begin
          errors++;
          $display("FAIL disp_data cyc%0d got valid=%b data=%h want 1/%h", i, disp_valid, disp_data, exp_d[i-1]);
        end
      end
      step();
    end
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (gnts != 5) begin
      errors++;
      $display("FAIL disp_gnt_count got %0d want 5", gnts);
    end
    checks++;
    if (disp_valid !== 1'b1 || disp_data !== exp_d[4] || vram_we !== 1'b1 || vram_addr !== 14'h0580 || vram_wdata !== 8'hD1) begin
      errors++;
      $display("FAIL disp_release got valid=%b data=%h we=%b addr=%h wdata=%h want 1/%h/1/0580/d1",
               disp_valid, disp_data, vram_we, vram_addr, vram_wdata, exp_d[4]);
    end
    model_wr(8'hD1);
    step();
  endtask

  task automatic test_overrun();
    disp_req = 1'b1; disp_addr = 14'h0002;
    wr0(8'h5A); wr0(8'hA5);
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr !== 1'b1 || vram_we !== 1'b1 || vram_wdata !== 8'h5A || vram_addr !== m_addr) begin
      errors++;
      $display("FAIL overrun got ovr=%b we=%b wdata=%h addr=%h want 1/1/5a/%h", ovr, vram_we, vram_wdata, vram_addr, m_addr);
    end
    model_wr(8'h5A);
    step();
    rd1();
    @(negedge clk);
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b want 0", ovr);
    end
    step();
  endtask

  task automatic test_byte_reset();
    wr1(8'h10); rd1(); wr1(8'h20); wr1(8'h40);
    wr0(8'h99);
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h0020) begin
      errors++;
      $display("FAIL byte_reset got we=%b addr=%h want 1/0020", vram_we, vram_addr);
    end
    m_addr = 14'h0020; model_wr(8'h99);
    step();
  endtask

  task automatic test_load_during_capture();
    rd0(); wr1(8'hC8); wr1(8'h43);
    m_rdbuf = ref_get(m_addr);
    m_addr  = 14'h03C8;
    @(negedge clk);
    checks++;
    if (dout !== m_rdbuf || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_capture got dout=%h busy=%b want %h/0", dout, busy, m_rdbuf);
    end
    step();
    wr0(8'h66);
    @(negedge clk);
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== 14'h03C8) begin
      errors++;
      $display("FAIL load_no_incr got we=%b addr=%h want 1/03c8", vram_we, vram_addr);
    end
    model_wr(8'h66);
    step();
  endtask

  task automatic test_echo();
    wr1(8'h00); wr1(8'h41);
    m_addr = 14'h0100;
    wr0(8'h77);
    model_wr(8'h77);
    step();
    @(negedge clk);
    checks++;
    if (dout !== m_rdbuf) begin
      errors++;
      $display("FAIL echo got dout=%h want %h", dout, m_rdbuf);
    end
    step();
  endtask

  task automatic test_random();
    logic        pr, bsy;
    logic [7:0]  pd, wd, lo;
    logic [13:0] ea;
    logic [5:0]  hi;
    int          op, nwe, k;
    reset = 1'b1; step(); reset = 1'b0;
    m_addr = 14'h0; m_rdbuf = 8'h00;
    step();
    pr = 1'b0; pd = 8'h00;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 4);
      lo = 8'($urandom); hi = 6'($urandom); wd = 8'($urandom);
      case (op)
        0: begin wr1(lo); wr1({2'b00, hi}); m_addr = {hi, lo}; end
        1: begin wr1(lo); wr1({2'b01, hi}); m_addr = {hi, lo}; end
        2: wr0(wd);
        3: rd0();
        default: begin wr1(lo); wr1({1'b1, 1'($urandom), hi}); end
      endcase
      ea = m_addr; nwe = 0; k = 0;
      do begin
        disp_req  = ($urandom_range(0, 3) == 0);
        disp_addr = 14'($urandom);
        @(negedge clk);
        checks++;
        if (disp_valid !== pr || (pr && disp_data !== pd)) begin
          errors++;
          $display("FAIL rand_disp_valid op%0d got valid=%b data=%h want %b/%h", n, disp_valid, disp_data, pr, pd);
        end
        if (disp_req) begin
          checks++;
          if (disp_gnt !== 1'b1 || vram_re !== 1'b1 || vram_we !== 1'b0 || vram_addr !== disp_addr) begin
            errors++;
            $display("FAIL rand_disp_gnt op%0d got gnt=%b re=%b we=%b addr=%h want 1/1/0/%h", n, disp_gnt, vram_re, vram_we, vram_addr, disp_addr);
          end
          pd = ref_get(disp_addr);
        end else if (vram_we === 1'b1) begin
          nwe++;
          checks++;
          if (op != 2 || vram_addr !== ea || vram_wdata !== wd) begin
            errors++;
            $display("FAIL rand_write op%0d got addr=%h data=%h want %h/%h", n, vram_addr, vram_wdata, ea, wd);
          end
          ref_mem[ea] = wd;
        end else if (vram_re === 1'b1) begin
          checks++;
          if ((op != 0 && op != 3) || vram_addr !== ea) begin
            errors++;
            $display("FAIL rand_read_issue op%0d got addr=%h want %h", n, vram_addr, ea);
          end
        end
        pr  = disp_req;
        bsy = busy;
        step();
        k++;
      end while (bsy && k < 60);
      disp_req = 1'b0;
      @(negedge clk);
      checks++;
      if (bsy || disp_valid !== pr || (pr && disp_data !== pd)) begin
        errors++;
        $display("FAIL rand_timeout_or_valid op%0d got busy=%b valid=%b data=%h want 0/%b/%h", n, bsy, disp_valid, disp_data, pr, pd);
      end
      pr = 1'b0;
      if (op == 2) begin
        m_addr = m_addr + 14'd1;
`ifdef VDP_WRBUF_ECHO_EN
        m_rdbuf = wd;
`endif
      end else if (op == 0 || op == 3) begin
        model_rd();
      end
      checks++;
      if (nwe != (op == 2 ? 1 : 0) || dout !== m_rdbuf || ovr !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_op op%0d kind%0d got writes=%0d dout=%h ovr=%b busy=%b want %0d/%h/0/0",
                 n, op, nwe, dout, ovr, busy, (op == 2 ? 1 : 0), m_rdbuf);
      end
      step();
    end
  endtask

  initial begin
    wr0_tick = 1'b0; rd0_tick = 1'b0; wr1_tick = 1'b0; rd1_tick = 1'b0;
    din = 8'h00; disp_req = 1'b0; disp_addr = 14'h0;
    poke_en = 1'b0; poke_addr = 14'h0; poke_dat = 8'h00;
    mem_clr = 1'b1; reset = 1'b1;
    m_addr = 14'h0; m_rdbuf = 8'h00;
    test_reset();
    test_write();
    test_read_wrap();
    test_disp_priority();
    test_overrun();
    test_byte_reset();
    test_load_during_capture();
    test_echo();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
